psdsqrt_seq: RTL and testbench
==============================

# psdsqrt_seq

Parametrised sequential square-root unit: computes the square root of an unsigned NBITSIN-bit integer to FRAC fractional bits with a multiplier-free restoring digit recurrence, one result bit per clock. It then rounds to an integer under a run-time-selectable rounding mode and saturates on overflow. It replaces the start/stop-driven square-root core in the processing datapath: completion is self-timed with busy/done, so the host no longer counts cycles to assert stop.

## Interface
- NBITSIN, 32, radicand width; even, 4..64 inclusive.
- FRAC, 4, fractional result bits computed before rounding; 1..16.
- clock  in  1  master clock, rising edge.
- reset  in  1  synchronous reset, active high.
- start  in  1  one-cycle request; sampled only while busy=0.
- xin  in  NBITSIN  unsigned integer operand, sampled on the accepted start edge.
- rmode  in  2  rounding mode, sampled with xin: 0 floor, 1 nearest, 2 ceiling, 3 nearest.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; sqrt valid and updated in the same cycle.
- sqrt  out  NBITSIN/2  rounded, saturated integer root; holds until the next done.

## Operation
- NR = NBITSIN/2 + FRAC. Internal radicand = xin << 2*FRAC (2*NR bits). Root register is NR bits; the partial remainder is NR+2 bits, signed for the trial subtraction.
- FSM states:
  - IDLE: start=1 latches the radicand and rmode, clears root and remainder, loads iteration counter = NR-1, and moves to CALC.
  - CALC: each cycle shifts the two next radicand bits into the remainder and trial-subtracts (root<<2)|1. If the result is ≥0, it keeps the result and shifts a 1 into root; otherwise it shifts in a 0. After the counter reaches 0, the FSM moves to ROUND.
  - ROUND: computes the integer I = root[NR-1:FRAC].
    - floor: I.
    - nearest: I + root[FRAC-1]. An exact .5 tie is impossible for integer radicands, so no tie rule is needed.
    - ceiling: I + 1 if any of root[FRAC-1:0] or the final remainder is nonzero.
    - The result is registered into sqrt, done pulses, and the FSM returns to IDLE.
- Saturation: if the rounded value equals 2^(NBITSIN/2), sqrt = all ones. This happens only for the largest operands under nearest or ceiling.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- xin and rmode changes after the accepted start edge have no effect.

## Timing
- Reset (any state, including mid-CALC) forces IDLE, busy=0, done=0, sqrt=0, and clears internal registers on the next edge. Reset wins over a simultaneous start.
- Edge E0 accepts start. busy is 1 from the cycle after E0 through the ROUND cycle.
- done=1 and the new sqrt appear after edge E0+NR+1; busy falls at that same edge. Total latency is NR+1 clocks (21 for the defaults).
- start may be asserted in the cycle in which done=1. It is accepted at the next edge, giving back-to-back throughput of one result per NR+2 clocks.
- done is never asserted for two consecutive cycles.

## Configuration
- PSDSQRT_FIXOUT_EN defined: adds output port sqrt_fix, out, NR bits, carrying the unrounded fixed-point root (FRAC fractional bits). It updates with done, resets to 0, and holds otherwise.
- Not defined: the port and its register are absent, and the root register may be discarded after ROUND. Core behaviour and timing are identical in both builds.

## Structure
- Package psdsqrt_pkg holds:
  - rmode constants: RM_FLOOR=2'd0, RM_NEAREST=2'd1, RM_CEIL=2'd2.
  - FSM state typedef: IDLE, CALC, ROUND.
  - the elaboration check 4≤NBITSIN≤64, NBITSIN even, 1≤FRAC≤16. The check fails compilation otherwise, rather than silently zeroing.
- One sub-module, psdsqrt_rnd: combinational rounding and saturation, taking root, remainder-nonzero and rmode and producing NBITSIN/2 bits. Instantiated once in the ROUND path.

## Test plan
- Defaults (32/4), xin=16 under all three rmodes -> sqrt=4 each; done after exactly 21 clocks; busy high for 21 cycles.
- xin=17: floor -> 4, nearest -> 4, ceiling -> 5. xin=21 (4.583): nearest -> 5. xin=20 (4.472): nearest -> 4.
- xin=0 -> sqrt=0 in all modes. xin=0xFFFFFFFF: floor -> 0xFFFF, nearest -> 0xFFFF (saturated), ceiling -> 0xFFFF (saturated).
- Start at xin=100; pulse start with xin=9 mid-CALC -> ignored, result 10. Start re-asserted in the done cycle -> accepted, next done 22 clocks later.
- Reset asserted at CALC iteration 10 -> next cycle busy=0, sqrt=0, and no done pulse. A following start with xin=49 -> 7.
- With PSDSQRT_FIXOUT_EN, NBITSIN=8, FRAC=4, xin=2 -> sqrt_fix=0x16 (1.375), sqrt=1 (nearest).

Source files
------------

// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the sequential square-root unit: rounding-mode codes,
// FSM state encoding and the parameter legality check used at elaboration.
package psdsqrt_pkg;

    localparam logic [1:0] RM_FLOOR   = 2'd0;
    localparam logic [1:0] RM_NEAREST = 2'd1;
    localparam logic [1:0] RM_CEIL    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2
    } state_t;

    function automatic bit cfg_ok(input int nbitsin, input int frac);
        return (nbitsin >= 4) && (nbitsin <= 64) && ((nbitsin % 2) == 0) &&
               (frac >= 1) && (frac <= 16);
    endfunction

endpackage

// File: rtl/psdsqrt_rnd.sv
// Combinational rounding of the fixed-point root to an integer, with saturation
// to all ones when rounding carries out of the NBITSIN/2-bit result.
module psdsqrt_rnd
    import psdsqrt_pkg::*;
#(
    parameter int NBITSIN = 32,
    parameter int FRAC    = 4
) (
    input  logic [NBITSIN/2+FRAC-1:0] root,
    input  logic                      rem_nz,
    input  logic [1:0]                rmode,
    output logic [NBITSIN/2-1:0]      rounded
);

    localparam int HW = NBITSIN / 2;
    localparam int NR = HW + FRAC;

    function automatic logic [HW-1:0] round_sat(input logic [NR-1:0] r,
                                                input logic          nz,
                                                input logic [1:0]    m);
        logic [HW-1:0] int_part;
        logic          inc;
        logic [HW:0]   sum;
        int_part = r[NR-1:FRAC];
        case (m)
            RM_FLOOR: inc = 1'b0;
            RM_CEIL:  inc = (|r[FRAC-1:0]) | nz;
            // Modes 1 and 3 both round to nearest; a .5 tie cannot occur.
            default:  inc = r[FRAC-1];
        endcase
        sum = {1'b0, int_part} + {{HW{1'b0}}, inc};
        return sum[HW] ? {HW{1'b1}} : sum[HW-1:0];
    endfunction

    assign rounded = round_sat(root, rem_nz, rmode);

endmodule

// File: rtl/psdsqrt_seq.sv
// Sequential restoring square root, one root bit per clock, then rounding.
// Optional fixed-point output port enabled by defining PSDSQRT_FIXOUT_EN.
module psdsqrt_seq
    import psdsqrt_pkg::*;
#(
    parameter int NBITSIN = 32,
    parameter int FRAC    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NBITSIN-1:0]        xin,
    input  logic [1:0]                rmode,
    output logic                      busy,
    output logic                      done,
    output logic [NBITSIN/2-1:0]      sqrt
`ifdef PSDSQRT_FIXOUT_EN
    ,
    output logic [NBITSIN/2+FRAC-1:0] sqrt_fix
`endif
);

    localparam int HW = NBITSIN / 2;
    localparam int NR = HW + FRAC;
    localparam int CW = $clog2(NR);

    if (!cfg_ok(NBITSIN, FRAC)) begin : g_cfg_err
        $error("psdsqrt_seq: NBITSIN must be even in 4..64 and FRAC in 1..16");
    end

    state_t                state_q;
    state_t                state_d;
    logic [2*NR-1:0]       rad_q;
    logic [NR-1:0]         root_q;
    logic signed [NR+1:0]  rem_q;
    logic [1:0]            mode_q;
    logic [CW-1:0]         cnt_q;
    logic [HW-1:0]         sqrt_q;
    logic                  done_q;

    logic [NR+1:0]         rem_shift;
    logic signed [NR+1:0]  trial;
    logic [HW-1:0]         rounded;

    // Wrapping difference is exact: the true trial value always fits NR+2 signed bits.
    assign rem_shift = {rem_q[NR-1:0], rad_q[2*NR-1 -: 2]};
    assign trial     = $signed(rem_shift - {root_q, 2'b01});

    psdsqrt_rnd #(
        .NBITSIN (NBITSIN),
        .FRAC    (FRAC)
    ) u_rnd (
        .root    (root_q),
        .rem_nz  (rem_q != '0),
        .rmode   (mode_q),
        .rounded (rounded)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            mode_q  <= RM_FLOOR;
            cnt_q   <= '0;
            sqrt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ROUND);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rad_q  <= {xin, {(2*FRAC){1'b0}}};
                        mode_q <= rmode;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= CW'(NR - 1);
                    end
                end
                CALC: begin
                    rad_q <= rad_q << 2;
                    cnt_q <= cnt_q - CW'(1);
                    if (!trial[NR+1]) begin
                        rem_q  <= trial;
                        root_q <= {root_q[NR-2:0], 1'b1};
                    end else begin
                        rem_q  <= rem_shift;
                        root_q <= {root_q[NR-2:0], 1'b0};
                    end
                end
                ROUND: sqrt_q <= rounded;
                default: ;
            endcase
        end
    end

`ifdef PSDSQRT_FIXOUT_EN
    logic [NR-1:0] fix_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fix_q <= '0;
        end else if (state_q == ROUND) begin
            fix_q <= root_q;
        end
    end

    assign sqrt_fix = fix_q;
`endif

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sqrt = sqrt_q;

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Directed bench for psdsqrt_seq at the default 32/4 configuration, plus an
// 8/4 instance exercising sqrt_fix when PSDSQRT_FIXOUT_EN is defined.
module tb_psdsqrt_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] xin;
    logic [1:0]  rmode;
    logic        busy;
    logic        done;
    logic [15:0] sqrt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

`ifdef PSDSQRT_FIXOUT_EN
    logic [19:0] sqrt_fix;
    logic        start8;
    logic [7:0]  xin8;
    logic [1:0]  rmode8;
    logic        busy8;
    logic        done8;
    logic [3:0]  sqrt8;
    logic [7:0]  fix8;

    psdsqrt_seq dut (
        .clock(clock), .reset(reset), .start(start), .xin(xin), .rmode(rmode),
        .busy(busy), .done(done), .sqrt(sqrt), .sqrt_fix(sqrt_fix)
    );

    psdsqrt_seq #(.NBITSIN(8), .FRAC(4)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .xin(xin8), .rmode(rmode8),
        .busy(busy8), .done(done8), .sqrt(sqrt8), .sqrt_fix(fix8)
    );
`else
    psdsqrt_seq dut (
        .clock(clock), .reset(reset), .start(start), .xin(xin), .rmode(rmode),
        .busy(busy), .done(done), .sqrt(sqrt)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait for done; lat counts negedges after the
    // accepting edge, busyc counts busy samples before done.
    task automatic run_op(input logic [31:0] x, input logic [1:0] m,
                          output int lat, output int busyc);
        @(negedge clock);
        start = 1'b1;
        xin   = x;
        rmode = m;
        @(negedge clock);
        start = 1'b0;
        xin   = ~x;
        rmode = ~m;
        lat   = 0;
        busyc = 0;
        while (!done && lat < 100) begin
            if (busy) busyc++;
            @(negedge clock);
            lat++;
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [1:0]  m;
        logic [15:0] e;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat;
        int busyc;
        int k;
        int nd;

        vecs[0]  = '{32'd16, 2'd0, 16'd4};
        vecs[1]  = '{32'd16, 2'd1, 16'd4};
        vecs[2]  = '{32'd16, 2'd2, 16'd4};
        vecs[3]  = '{32'd17, 2'd0, 16'd4};
        vecs[4]  = '{32'd17, 2'd1, 16'd4};
        vecs[5]  = '{32'd17, 2'd2, 16'd5};
        vecs[6]  = '{32'd21, 2'd1, 16'd5};
        vecs[7]  = '{32'd20, 2'd1, 16'd4};
        vecs[8]  = '{32'd0,  2'd0, 16'd0};
        vecs[9]  = '{32'd0,  2'd1, 16'd0};
        vecs[10] = '{32'd0,  2'd2, 16'd0};
        vecs[11] = '{32'hFFFF_FFFF, 2'd0, 16'hFFFF};
        vecs[12] = '{32'hFFFF_FFFF, 2'd1, 16'hFFFF};
        vecs[13] = '{32'hFFFF_FFFF, 2'd2, 16'hFFFF};
        vecs[14] = '{32'd21, 2'd3, 16'd5};
        vecs[15] = '{32'd24, 2'd2, 16'd5};

        reset = 1'b1;
        start = 1'b0;
        xin   = '0;
        rmode = '0;
`ifdef PSDSQRT_FIXOUT_EN
        start8 = 1'b0;
        xin8   = '0;
        rmode8 = '0;
`endif
        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_sqrt", {48'd0, sqrt}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].x, vecs[i].m, lat, busyc);
            check($sformatf("sqrt_v%0d", i), {48'd0, sqrt}, {48'd0, vecs[i].e});
            if (i == 0) begin
                check("latency", 64'(lat), 64'd21);
                check("busy_cycles", 64'(busyc), 64'd21);
            end
            check($sformatf("busy_at_done_v%0d", i), {63'd0, busy}, 64'd0);
            @(negedge clock);
            check($sformatf("done_pulse_v%0d", i), {63'd0, done}, 64'd0);
        end

        // Start pulsed mid-CALC must be ignored.
        @(negedge clock);
        start = 1'b1;
        xin   = 32'd100;
        rmode = 2'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start = 1'b1;
        xin   = 32'd9;
        rmode = 2'd0;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("ignored_start_done", {63'd0, done}, 64'd1);
        check("ignored_start_sqrt", {48'd0, sqrt}, 64'd10);

        // Back-to-back: start asserted in the done cycle.
        start = 1'b1;
        xin   = 32'd49;
        rmode = 2'd0;
        k = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            k++;
        end while (!done && k < 100);
        check("b2b_interval", 64'(k), 64'd22);
        check("b2b_sqrt", {48'd0, sqrt}, 64'd7);

        // Reset during CALC aborts the operation.
        @(negedge clock);
        start = 1'b1;
        xin   = 32'd100;
        rmode = 2'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_sqrt", {48'd0, sqrt}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op(32'd49, 2'd0, lat, busyc);
        check("after_abort_sqrt", {48'd0, sqrt}, 64'd7);
        check("after_abort_latency", 64'(lat), 64'd21);

`ifdef PSDSQRT_FIXOUT_EN
        @(negedge clock);
        start8 = 1'b1;
        xin8   = 8'd2;
        rmode8 = 2'd1;
        @(negedge clock);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("fix8_latency", 64'(k), 64'd9);
        check("fix8_sqrt_fix", {56'd0, fix8}, 64'h16);
        check("fix8_sqrt", {60'd0, sqrt8}, 64'd1);
        check("fix32_sqrt_fix", {44'd0, sqrt_fix}, 64'h70);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
